// File: rtl/uarch_pkg.sv
// Shared microarchitecture sizing and the writeback packet carried on the CDB.
// Imported by the CDB arbiter slice and its interface.
package uarch_pkg;

  localparam int unsigned NUM_FU          = 4;
  localparam int unsigned PIPE_WIDTH      = 2;
  localparam int unsigned TAG_WIDTH       = 5;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned CDB_ARB_NUM_REQ = NUM_FU;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;

  // Distance of a tag from the ROB head, wrapping at the tag space.
  function automatic logic [TAG_WIDTH-1:0] tag_age(input logic [TAG_WIDTH-1:0] tag,
                                                   input logic [TAG_WIDTH-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback-side and CDB-side bundle of the CDB arbiter.
// master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if
  import uarch_pkg::*;
#(
  parameter int unsigned NUM_REQ   = CDB_ARB_NUM_REQ,
  parameter int unsigned NUM_PORTS = PIPE_WIDTH
);

  writeback_packet_t [NUM_REQ-1:0]   fu_wb_pkts;
  logic              [NUM_REQ-1:0]   fu_wb_rdys;
  writeback_packet_t [NUM_PORTS-1:0] cdb_ports;
  logic              [TAG_WIDTH-1:0] rob_head;
  logic              [NUM_REQ-1:0]   grant_dbg;

  modport master (
    output fu_wb_pkts, rob_head,
    input  fu_wb_rdys, cdb_ports, grant_dbg
  );

  modport slave (
    input  fu_wb_pkts, rob_head,
    output fu_wb_rdys, cdb_ports, grant_dbg
  );

endinterface

// File: rtl/cdb_arbiter_pick_n.sv
// cdb_pick_n: combinational pick of up to NUM_PORTS requesters, port 0 first.
// Round-robin from rr_ptr, or oldest-first by age when CDB_AGE_PRIO_EN is defined.
module cdb_pick_n
  import uarch_pkg::*;
#(
  parameter int unsigned NUM_REQ   = CDB_ARB_NUM_REQ,
  parameter int unsigned NUM_PORTS = PIPE_WIDTH,
  parameter int unsigned PTR_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                  req,
`ifdef CDB_AGE_PRIO_EN
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]   age,
`else
  input  logic [PTR_W-1:0]                    rr_ptr,
`endif
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_PORTS-1:0]                port_vld,
  output logic [NUM_PORTS-1:0][PTR_W-1:0]     port_idx
);

`ifdef CDB_AGE_PRIO_EN
  always_comb begin
    logic                 found;
    logic [TAG_WIDTH-1:0] best;
    logic [PTR_W-1:0]     sel;
    grant    = '0;
    port_vld = '0;
    port_idx = '0;
    found    = 1'b0;
    best     = '0;
    sel      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      found = 1'b0;
      best  = '0;
      sel   = '0;
      // Strict compare keeps the lower index on equal ages.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !grant[i] && (!found || age[i] < best)) begin
          found = 1'b1;
          best  = age[i];
          sel   = PTR_W'(i);
        end
      end
      if (found) begin
        grant[sel]  = 1'b1;
        port_vld[p] = 1'b1;
        port_idx[p] = sel;
      end
    end
  end
`else
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    int unsigned      idx;
    grant    = '0;
    port_vld = '0;
    port_idx = '0;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    idx      = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx  = (32'(rr_ptr) + k) % NUM_REQ;
        cand = PTR_W'(idx);
        if (!found && req[cand] && !grant[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      if (found) begin
        grant[sel]  = 1'b1;
        port_vld[p] = 1'b1;
        port_idx[p] = sel;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, up to NUM_PORTS grants per cycle onto
// registered CDB ports. Define CDB_AGE_PRIO_EN for ROB-age priority instead of round-robin.
module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int unsigned NUM_REQ   = CDB_ARB_NUM_REQ,
  parameter int unsigned NUM_PORTS = PIPE_WIDTH,
  parameter int unsigned PTR_W     = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  cdb_arbiter_if.slave bus
);

  writeback_packet_t [NUM_REQ-1:0]   hold_pkt_q, hold_pkt_d;
  logic              [NUM_REQ-1:0]   hold_valid_q, hold_valid_d;
  writeback_packet_t [NUM_PORTS-1:0] cdb_q, cdb_d;

  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              rdy;
  logic [NUM_PORTS-1:0]            port_vld;
  logic [NUM_PORTS-1:0][PTR_W-1:0] port_idx;

`ifdef CDB_AGE_PRIO_EN
  logic [NUM_REQ-1:0][TAG_WIDTH-1:0] age;

  always_comb begin
    age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i] = tag_age(hold_pkt_q[i].dest_tag, bus.rob_head);
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             unused_rob_head;

  assign unused_rob_head = ^bus.rob_head;
`endif

  cdb_pick_n #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_pick (
    .req     (hold_valid_q),
`ifdef CDB_AGE_PRIO_EN
    .age     (age),
`else
    .rr_ptr  (rr_ptr_q),
`endif
    .grant   (grant),
    .port_vld(port_vld),
    .port_idx(port_idx)
  );

  // Ready depends only on state, so FU packets never feed back into their own ready.
  always_comb begin
    rdy          = ~hold_valid_q | grant;
    hold_valid_d = hold_valid_q & ~grant;
    hold_pkt_d   = hold_pkt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i] && bus.fu_wb_pkts[i].is_valid) begin
        hold_valid_d[i] = 1'b1;
        hold_pkt_d[i]   = bus.fu_wb_pkts[i];
      end
    end
    cdb_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_vld[p]) begin
        cdb_d[p] = hold_pkt_q[port_idx[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= '0;
      hold_pkt_q   <= '0;
      cdb_q        <= '0;
    end else if (flush) begin
      hold_valid_q <= '0;
      cdb_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pkt_q   <= hold_pkt_d;
      cdb_q        <= cdb_d;
    end
  end

`ifndef CDB_AGE_PRIO_EN
  // Ports fill in grant order, so the last valid port holds the last granted index.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_vld[p]) begin
        rr_ptr_d = (32'(port_idx[p]) == NUM_REQ - 1) ? '0 : port_idx[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bus.fu_wb_rdys = rdy;
  assign bus.grant_dbg  = grant;
  assign bus.cdb_ports  = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter; a monitor checks every valid CDB port against a
// queue of hand-computed expected packets.
module tb_cdb_arbiter;
  import uarch_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned NPORT = 2;

  typedef struct {
    int             port;
    int             fu;
    logic [4:0]     tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NREQ), .NUM_PORTS(NPORT)) bus ();

  cdb_arbiter #(.NUM_REQ(NREQ), .NUM_PORTS(NPORT)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  function automatic logic [31:0] res(input int fu, input logic [4:0] tag);
    return 32'hA000_0000 | (32'(fu) << 8) | 32'(tag);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int port, input int fu, input int tag);
    exp_t e;
    e.port = port;
    e.fu   = fu;
    e.tag  = 5'(tag);
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs, check this cycle's grant/ready, then advance past the edge.
  task automatic apply(input logic rs, input logic fl, input logic [3:0] vld,
                       input int t0, input int t1, input int t2, input int t3,
                       input logic [3:0] eg, input logic [3:0] er, input string name);
    int t[4];
    t     = '{t0, t1, t2, t3};
    rst   = rs;
    flush = fl;
    for (int i = 0; i < 4; i++) begin
      bus.fu_wb_pkts[i].is_valid = vld[i];
      bus.fu_wb_pkts[i].dest_tag = 5'(t[i]);
      bus.fu_wb_pkts[i].result   = res(i, 5'(t[i]));
    end
    chk({name, "_grant"}, 32'(bus.grant_dbg), 32'(eg));
    chk({name, "_rdy"}, 32'(bus.fu_wb_rdys), 32'(er));
    @(posedge clk);
    #1;
    rst   = 1'b1;
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (bus.cdb_ports[p].is_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cdb_unexpected port %0d actual tag %0d required none", p,
                   bus.cdb_ports[p].dest_tag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cdb_port", 32'(p), 32'(mon_e.port));
          chk("cdb_tag", 32'(bus.cdb_ports[p].dest_tag), 32'(mon_e.tag));
          chk("cdb_result", bus.cdb_ports[p].result, res(mon_e.fu, mon_e.tag));
        end
      end
    end
  end

  initial begin
    bus.fu_wb_pkts = '0;
    bus.rob_head   = '0;
    rst            = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_cdb_zero", 32'(bus.cdb_ports != '0), 32'd0);
    chk("reset_rdy", 32'(bus.fu_wb_rdys), 32'hF);
    chk("reset_grant", 32'(bus.grant_dbg), 32'h0);
    rst = 1'b1;

`ifdef CDB_AGE_PRIO_EN
    bus.rob_head = 5'd30;
    push(0, 1, 31);
    push(1, 2, 1);
    push(0, 0, 29);
    apply(1, 0, 4'b0111, 29, 31, 1, 0, 4'b0000, 4'b1111, "age_c0");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0110, 4'b1110, "age_c1");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1111, "age_c2");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "age_c3");
`else
    // Single requester, two-cycle latency.
    push(0, 0, 5);
    apply(1, 0, 4'b0001, 5, 0, 0, 0, 4'b0000, 4'b1111, "single_c0");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1111, "single_c1");
    chk("single_p0_valid", 32'(bus.cdb_ports[0].is_valid), 32'd1);
    chk("single_p0_tag", 32'(bus.cdb_ports[0].dest_tag), 32'd5);
    chk("single_p1_valid", 32'(bus.cdb_ports[1].is_valid), 32'd0);
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "single_c2");
    apply(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "ptr_clear");

    // Full contention from rr_ptr 0; tag = fu*8 + sequence.
    push(0, 0, 0);  push(1, 1, 8);  push(0, 2, 16); push(1, 3, 24);
    push(0, 0, 1);  push(1, 1, 9);  push(0, 2, 17); push(1, 3, 25);
    apply(1, 0, 4'b1111, 0, 8, 16, 24, 4'b0000, 4'b1111, "full_c0");
    apply(1, 0, 4'b1111, 1, 9, 16, 24, 4'b0011, 4'b0011, "full_c1");
    apply(1, 0, 4'b1100, 0, 0, 17, 25, 4'b1100, 4'b1100, "full_c2");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0011, 4'b0011, "full_c3");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1100, 4'b1111, "full_c4");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "full_c5");

    // Backpressure on req3 holding tag 9; its stalled input change to 13 must be ignored.
    push(0, 0, 2);  push(1, 1, 10); push(0, 2, 18); push(1, 3, 9);
    push(0, 0, 3);  push(1, 1, 11); push(0, 2, 19);
    apply(1, 0, 4'b1111, 2, 10, 18, 9, 4'b0000, 4'b1111, "bp_c0");
    apply(1, 0, 4'b1111, 3, 11, 18, 13, 4'b0011, 4'b0011, "bp_c1");
    apply(1, 0, 4'b0100, 0, 0, 19, 0, 4'b1100, 4'b1100, "bp_c2");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0011, 4'b1011, "bp_c3");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b1111, "bp_c4");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "bp_c5");

    // Flush with hold_valid 1011 and a valid CDB; tags 4, 12, 28, 21 must never appear.
    push(0, 2, 20);
    push(0, 0, 6);  push(1, 2, 22); push(0, 3, 30);
    apply(1, 0, 4'b0100, 0, 0, 20, 0, 4'b0000, 4'b1111, "fl_c0");
    apply(1, 0, 4'b1011, 4, 12, 0, 28, 4'b0100, 4'b1111, "fl_c1");
    apply(1, 1, 4'b0100, 0, 0, 21, 0, 4'b1001, 4'b1101, "fl_c2");
    chk("fl_p0_invalid", 32'(bus.cdb_ports[0].is_valid), 32'd0);
    chk("fl_p1_invalid", 32'(bus.cdb_ports[1].is_valid), 32'd0);
    apply(1, 0, 4'b1101, 6, 0, 22, 30, 4'b0000, 4'b1111, "fl_c3");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0101, 4'b0111, "fl_c4");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1000, 4'b1111, "fl_c5");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "fl_c6");

    // Reset mid-traffic; held tags 19 and 27 are dropped, arbitration restarts at req0.
    push(0, 0, 3);  push(1, 1, 11);
    push(0, 0, 1);  push(1, 2, 17); push(0, 3, 25);
    apply(1, 0, 4'b1111, 3, 11, 19, 27, 4'b0000, 4'b1111, "rst_c0");
    apply(1, 0, 4'b1100, 0, 0, 19, 27, 4'b0011, 4'b0011, "rst_c1");
    apply(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1100, 4'b1111, "rst_c2");
    chk("rst_cdb_zero", 32'(bus.cdb_ports != '0), 32'd0);
    apply(1, 0, 4'b1101, 1, 0, 17, 25, 4'b0000, 4'b1111, "rst_c3");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0101, 4'b0111, "rst_c4");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1000, 4'b1111, "rst_c5");
    apply(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, "rst_c6");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the PIPE_WIDTH common data bus (CDB) ports among all functional-unit writeback requesters (ALUs, LSU, AGU, MDU).
- Sits between the execute-stage result outputs and the `cdb_ports` consumed by issue (reservation stations, LSQ), ROB and register status.
- Each requester has a one-entry holding register. Up to NUM_PORTS held results are granted per cycle, using a rotating round-robin priority.
- Results are driven on registered CDB outputs. Backpressure is returned to each FU through a ready signal.

Parameters:
- NUM_REQ, default NUM_FU (4): number of writeback requesters.
- NUM_PORTS, default PIPE_WIDTH (2): number of CDB ports driven.
- PTR_W, default $clog2(NUM_REQ): round-robin pointer width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  pipeline flush (mispredict/exception).
- fu_wb_pkts  input  writeback_packet_t [NUM_REQ]  per-FU result; valid when `.is_valid`=1.
- fu_wb_rdys  output  [NUM_REQ]  per-FU ready; the FU holds its packet while 0.
- cdb_ports  output  writeback_packet_t [NUM_PORTS]  registered CDB broadcast.
- rob_head  input  TAG_WIDTH  ROB head tag; used only when CDB_AGE_PRIO_EN is defined.
- grant_dbg  output  [NUM_REQ]  grant vector of the current cycle, for verification and performance hooks.

Behaviour:
- State:
  - hold_pkt[i] and hold_valid[i] for each requester.
  - rr_ptr (PTR_W bits).
  - cdb_q[NUM_PORTS] output registers.
- Reset (rst==0 at posedge) clears:
  - hold_valid to all 0.
  - rr_ptr to 0.
  - cdb_q to all fields 0 (`.is_valid`=0).
  - After reset, fu_wb_rdys reads all 1 and grant_dbg all 0.
- Arbitration (combinational, from state only):
  - Scan held entries in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first min(NUM_PORTS, count of hold_valid) entries.
  - grant_dbg equals the grant vector.
- Ready:
  - fu_wb_rdys[i] = ~hold_valid[i] | grant[i].
  - There is no combinational path from fu_wb_pkts to fu_wb_rdys.
- Capture:
  - At posedge, when fu_wb_rdys[i] and fu_wb_pkts[i].is_valid, hold_pkt[i] loads the packet and hold_valid[i] is set.
  - Otherwise, a granted entry clears hold_valid[i].
  - A capture in the same cycle as a grant refills the slot, giving a throughput of 1 result per requester per cycle.
- Output:
  - Granted packets load cdb_q in grant order: the first granted requester goes to port 0.
  - Unused ports load `.is_valid`=0.
- Pointer update:
  - rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - rr_ptr is unchanged when nothing is granted.
- Latency:
  - A packet accepted at the edge ending cycle t appears on cdb_ports in cycle t+2 when uncontended.
  - Worst-case wait is ceil(NUM_REQ/NUM_PORTS) arbitration cycles (starvation-free).
- Flush (flush==1 at posedge, rst==1):
  - hold_valid and cdb_q `.is_valid` are cleared and rr_ptr is set to 0.
  - Packets presented that cycle are discarded.
  - Grants computed that cycle have no effect.
  - Reset has priority over flush.
- Boundaries:
  - All requesters full: exactly NUM_PORTS grants.
  - Zero held entries: all cdb_q ports invalid.
  - Pointer wraps at NUM_REQ-1 to 0.
  - A held packet is never altered while un-granted, even if the FU input changes.

Optional Feature:
- Macro: CDB_AGE_PRIO_EN.
- Defined: priority is by age, where age = (hold_pkt[i].dest_tag - rob_head) mod 2^TAG_WIDTH.
  - The smallest ages are granted first; ties go to the lower index.
  - Grants are placed on ports oldest-first.
  - rr_ptr is not instantiated.
- Undefined: round-robin as above, and rob_head is ignored.

Decomposition:
- uarch_pkg holds NUM_FU, PIPE_WIDTH, TAG_WIDTH and writeback_packet_t (fields is_valid, dest_tag, result).
- uarch_pkg also gains CDB_ARB_NUM_REQ.
- Sub-module: cdb_pick_n, a combinational pick-first-N-from-rotated-vector that returns the grant vector and per-port indices.
  - Its age-compare variant is selected by the macro.

Test Plan (NUM_REQ=4, NUM_PORTS=2, TAG_WIDTH=5):
- Single requester: req0 presents dest_tag 5 in cycle t -> cdb_ports[0] holds tag 5, valid, in t+2; port1 is invalid; fu_wb_rdys stays 1111.
- Full contention: all 4 requesters present every cycle from rr_ptr=0 -> grant_dbg sequence 0011, 1100, 0011; each result appears exactly once, in per-requester order.
- Backpressure: req3 holds tag 9 while req0–2 stream -> fu_wb_rdys[3]=0 until granted (at most 2 arbitration cycles); FU-side change of input is not captured; tag 9 is never lost or duplicated.
- Flush with hold_valid=1011 and cdb valid -> next cycle cdb_ports all invalid, fu_wb_rdys 1111, rr_ptr 0, and none of the flushed tags ever appear.
- Reset: rst=0 for one cycle mid-traffic -> all outputs are 0 the following cycle; traffic resumes and the first grant starts from req0.
- CDB_AGE_PRIO_EN, rob_head=30, held tags req0=29, req1=31, req2=1 -> port0 gets tag 31 (age 1) and port1 gets tag 1 (age 3); tag 29 (age 31) is granted the next cycle.
